// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART state encodings, parity constants and legal ranges.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam logic C_PAR_EVEN = 1'b0;
  localparam logic C_PAR_ODD  = 1'b1;

  localparam int C_DATA_W_MIN = 5;
  localparam int C_DATA_W_MAX = 9;
  localparam int C_STOP_W_MIN = 1;
  localparam int C_STOP_W_MAX = 2;

  function automatic bit data_w_legal(input int w);
    return (w >= C_DATA_W_MIN) && (w <= C_DATA_W_MAX);
  endfunction

  function automatic bit stop_w_legal(input int w);
    return (w >= C_STOP_W_MIN) && (w <= C_STOP_W_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_parity_gen.sv
// ---------------------------------------------------------------------------
// uart_parity_gen : XOR reduction of a data word with odd/even select.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  output logic              o_parity
);

  assign o_parity = (^i_data) ^ i_odd;

endmodule

`default_nettype wire

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer : tick-driven UART receive deframer with valid/ready output.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STOP_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_tick,
  input  logic              rx_bit,
  input  logic              par_en,
  input  logic              par_odd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = 4;

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("uart_rx_deframer: DATA_W out of range");
  end
  if (!stop_w_legal(STOP_W)) begin : g_bad_stop_w
    $error("uart_rx_deframer: STOP_W out of range");
  end

  rx_state_e         r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [1:0]        r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en;
  logic              r_par_odd;
  logic              r_par_bit;
  logic              r_ferr;
  logic              r_stop_any1;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_break_det;
  logic              r_overrun;
  logic              r_busy;

  logic w_par_exp;
  logic w_last_stop;
  logic w_done;
  logic w_ferr_now;
  logic w_perr_now;
  logic w_brk_now;

  uart_parity_gen #(
    .DATA_W (DATA_W)
  ) u_par (
    .i_data   (r_shift),
    .i_odd    (r_par_odd),
    .o_parity (w_par_exp)
  );

  // Frame status is evaluated combinationally against the final stop sample.
  assign w_last_stop = (r_stop_cnt == 2'(STOP_W - 1));
  assign w_done      = bit_tick && (r_state == ST_STOP) && w_last_stop;
  assign w_ferr_now  = r_ferr | ~rx_bit;
  assign w_perr_now  = r_par_en & (r_par_bit != w_par_exp);
  assign w_brk_now   = (r_shift == '0) && !(r_par_en && r_par_bit) && !(r_stop_any1 || rx_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_par_bit    <= 1'b0;
      r_ferr       <= 1'b0;
      r_stop_any1  <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break_det  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_overrun <= 1'b0;

      if (bit_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!rx_bit) begin
              r_state     <= ST_DATA;
              r_busy      <= 1'b1;
              r_par_en    <= par_en;
              r_par_odd   <= par_odd;
              r_bit_cnt   <= '0;
              r_stop_cnt  <= '0;
              r_shift     <= '0;
              r_par_bit   <= 1'b0;
              r_ferr      <= 1'b0;
              r_stop_any1 <= 1'b0;
            end
          end
          ST_DATA: begin
            // Right shift: the first (LSB) bit ends up at position 0.
            r_shift   <= {rx_bit, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            r_par_bit <= rx_bit;
            r_state   <= ST_STOP;
          end
          ST_STOP: begin
            r_ferr      <= w_ferr_now;
            r_stop_any1 <= r_stop_any1 | rx_bit;
            if (w_last_stop) begin
              r_state <= w_ferr_now ? ST_WAIT_HIGH : ST_IDLE;
              r_busy  <= w_ferr_now;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
          ST_WAIT_HIGH: begin
            if (rx_bit) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

      if (w_done) begin
        if (!r_out_valid || out_ready) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_shift;
          r_parity_err <= w_perr_now;
          r_frame_err  <= w_ferr_now;
          r_break_det  <= w_brk_now;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign break_det  = r_break_det;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer : directed bench over 8N1, 8-bit/2-stop and 7-bit configs.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_deframer;

  logic clk = 1'b0;
  logic rst_n;
  logic bit_tick;
  logic rx_bit;
  logic par_en;
  logic par_odd;
  logic out_ready;

  logic [7:0] a_data;
  logic       a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
  logic [7:0] b_data;
  logic       b_valid, b_perr, b_ferr, b_brk, b_ovr, b_busy;
  logic [6:0] c_data;
  logic       c_valid, c_perr, c_ferr, c_brk, c_ovr, c_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_deframer #(.DATA_W(8), .STOP_W(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .rx_bit(rx_bit),
    .par_en(par_en), .par_odd(par_odd), .out_data(a_data), .out_valid(a_valid),
    .out_ready(out_ready), .parity_err(a_perr), .frame_err(a_ferr),
    .break_det(a_brk), .overrun(a_ovr), .busy(a_busy)
  );

  uart_rx_deframer #(.DATA_W(8), .STOP_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .rx_bit(rx_bit),
    .par_en(par_en), .par_odd(par_odd), .out_data(b_data), .out_valid(b_valid),
    .out_ready(out_ready), .parity_err(b_perr), .frame_err(b_ferr),
    .break_det(b_brk), .overrun(b_ovr), .busy(b_busy)
  );

  uart_rx_deframer #(.DATA_W(7), .STOP_W(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .rx_bit(rx_bit),
    .par_en(par_en), .par_odd(par_odd), .out_data(c_data), .out_valid(c_valid),
    .out_ready(out_ready), .parity_err(c_perr), .frame_err(c_ferr),
    .break_det(c_brk), .overrun(c_ovr), .busy(c_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bit per tick; returns at the negedge after the consuming posedge.
  task automatic tick(input logic b);
    @(negedge clk);
    rx_bit   = b;
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    rx_bit   = 1'b1;
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                            input logic pbit, input logic [1:0] stops, input int ns);
    tick(1'b0);
    for (int i = 0; i < nb; i++) tick(d[i]);
    if (has_par) tick(pbit);
    for (int i = 0; i < ns; i++) tick(stops[i]);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_tick  = 1'b0;
    rx_bit    = 1'b1;
    par_en    = 1'b0;
    par_odd   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_valid", 32'(a_valid), 32'd0);
    check_eq("rst_data",  32'(a_data),  32'h0);
    check_eq("rst_busy",  32'(a_busy),  32'd0);
    check_eq("rst_flags", {29'd0, a_perr, a_ferr, a_brk}, 32'd0);
    check_eq("rst_ovr",   32'(a_ovr),   32'd0);

    // 8N1 0x55: stop tick held back to observe 1-clk latency.
    send_frame(9'h055, 8, 1'b0, 1'b0, 2'b00, 0);
    check_eq("n81_busy_mid",  32'(a_busy),  32'd1);
    check_eq("n81_valid_mid", 32'(a_valid), 32'd0);
    tick(1'b1);
    check_eq("n81_valid", 32'(a_valid), 32'd1);
    check_eq("n81_data",  32'(a_data),  32'h55);
    check_eq("n81_flags", {29'd0, a_perr, a_ferr, a_brk}, 32'd0);
    check_eq("n81_busy",  32'(a_busy),  32'd0);
    consume();
    check_eq("n81_drain", 32'(a_valid), 32'd0);

    // Even parity 0xA3 (four ones -> parity 0).
    par_en = 1'b1; par_odd = 1'b0;
    send_frame(9'h0A3, 8, 1'b1, 1'b0, 2'b01, 1);
    check_eq("ev_ok_data", 32'(a_data), 32'hA3);
    check_eq("ev_ok_perr", 32'(a_perr), 32'd0);
    consume();
    send_frame(9'h0A3, 8, 1'b1, 1'b1, 2'b01, 1);
    check_eq("ev_bad_data", 32'(a_data), 32'hA3);
    check_eq("ev_bad_perr", 32'(a_perr), 32'd1);
    check_eq("ev_bad_ferr", 32'(a_ferr), 32'd0);
    consume();
    par_en = 1'b0;

    // Two stop bits, second one low.
    do_reset();
    send_frame(9'h03C, 8, 1'b0, 1'b0, 2'b01, 2);
    check_eq("s2_data", 32'(b_data), 32'h3C);
    check_eq("s2_ferr", 32'(b_ferr), 32'd1);
    check_eq("s2_brk",  32'(b_brk),  32'd0);
    check_eq("s2_busy_wait", 32'(b_busy), 32'd1);
    consume();
    tick(1'b0);
    check_eq("s2_start_ignored", 32'(b_busy), 32'd1);
    tick(1'b0);
    check_eq("s2_still_wait", 32'(b_busy), 32'd1);
    tick(1'b1);
    check_eq("s2_idle", 32'(b_busy), 32'd0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 2'b11, 2);
    check_eq("s2_good_valid", 32'(b_valid), 32'd1);
    check_eq("s2_good_ferr",  32'(b_ferr),  32'd0);
    consume();

    // Break on the 8N1 instance.
    do_reset();
    send_frame(9'h000, 8, 1'b0, 1'b0, 2'b00, 1);
    check_eq("brk_valid", 32'(a_valid), 32'd1);
    check_eq("brk_data",  32'(a_data),  32'h0);
    check_eq("brk_ferr",  32'(a_ferr),  32'd1);
    check_eq("brk_det",   32'(a_brk),   32'd1);
    check_eq("brk_busy",  32'(a_busy),  32'd1);
    consume();
    tick(1'b1);
    check_eq("brk_recover", 32'(a_busy), 32'd0);

    // Overrun and completion coinciding with ready.
    do_reset();
    send_frame(9'h011, 8, 1'b0, 1'b0, 2'b01, 1);
    check_eq("ovr_first", 32'(a_data), 32'h11);
    send_frame(9'h022, 8, 1'b0, 1'b0, 2'b01, 1);
    check_eq("ovr_pulse", 32'(a_ovr),   32'd1);
    check_eq("ovr_hold",  32'(a_data),  32'h11);
    @(negedge clk);
    check_eq("ovr_pulse_end", 32'(a_ovr),   32'd0);
    check_eq("ovr_valid",     32'(a_valid), 32'd1);
    check_eq("ovr_hold2",     32'(a_data),  32'h11);
    send_frame(9'h022, 8, 1'b0, 1'b0, 2'b00, 0);
    @(negedge clk);
    rx_bit = 1'b1; bit_tick = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0; out_ready = 1'b0;
    check_eq("coin_data",  32'(a_data),  32'h22);
    check_eq("coin_valid", 32'(a_valid), 32'd1);
    check_eq("coin_ovr",   32'(a_ovr),   32'd0);
    consume();

    // Reset mid-frame, then 7-bit odd-parity 0x7E (six ones -> parity 1).
    par_en = 1'b1; par_odd = 1'b1;
    send_frame(9'h07E, 4, 1'b0, 1'b0, 2'b00, 0);
    check_eq("mid_busy", 32'(c_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_busy",  32'(c_busy),  32'd0);
    check_eq("mid_rst_valid", 32'(c_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0);
    par_en = 1'b0; par_odd = 1'b0;
    for (int i = 0; i < 7; i++) tick(1'(7'h7E >> i));
    tick(1'b1);
    tick(1'b1);
    check_eq("p7_valid", 32'(c_valid), 32'd1);
    check_eq("p7_data",  32'(c_data),  32'h7E);
    check_eq("p7_perr",  32'(c_perr),  32'd0);
    check_eq("p7_ferr",  32'(c_ferr),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Parametrised serial-input UART receive deframer for the full-duplex UART core; successor to the combinational 8N1 word deframer.
- Consumes one sampled line bit per bit_tick (mid-bit strobe from the baud generator / oversampler).
- Assembles start, DATA_W data bits (LSB first), optional parity and STOP_W stop bits.
- Checks framing and parity, then presents each byte on a registered valid/ready output with per-frame error flags.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9.
STOP_W, 1, stop bits checked; legal 1 or 2.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
bit_tick  input  1  one-cycle strobe, rx_bit valid this cycle.
rx_bit  input  1  synchronised, mid-bit-sampled serial line.
par_en  input  1  parity bit present; latched at start bit.
par_odd  input  1  1 = odd parity, 0 = even; latched at start bit.
out_data  output  DATA_W  received data word.
out_valid  output  1  out_data and flags valid.
out_ready  input  1  consumer accepts when out_valid and out_ready.
parity_err  output  1  parity mismatch for held frame (0 when par_en was 0).
frame_err  output  1  any stop bit sampled 0 for held frame.
break_det  output  1  data all-zero, parity (if any) 0, and all stop bits 0.
overrun  output  1  one-cycle pulse: completed frame dropped.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: FSM=IDLE; out_data=0; out_valid, parity_err, frame_err, break_det, overrun, busy all 0; bit counter and shift register 0. Reset mid-frame aborts the frame with no output.
- Only edges with bit_tick=1 advance the FSM. Non-tick cycles hold state except for output handshake logic.
- FSM states:
  - IDLE: tick with rx_bit=0 → DATA; latch par_en/par_odd; clear bit count. Tick with rx_bit=1 stays IDLE.
  - DATA: each tick shifts rx_bit into bit position count (LSB first). After the DATA_W-th bit → PARITY if latched par_en, else STOP.
  - PARITY: tick samples the parity bit → STOP.
  - STOP: STOP_W ticks, each sampled; any 0 sets the internal frame error. On the last stop tick the frame completes → IDLE, or → WAIT_HIGH if a frame error occurred.
  - WAIT_HIGH: ignores start bits until a tick with rx_bit=1 → IDLE. This prevents a break or line-low condition from being re-framed.
- Parity check: expected = XOR(data) XOR par_odd; parity_err = sampled bit != expected.
- Completion edge (last stop tick), output register rules:
  - If out_valid=0, or out_valid=1 and out_ready=1 on that same edge: load out_data and flags, out_valid=1. Visible in the cycle after the edge; latency from final stop tick = 1 clk.
  - If out_valid=1 and out_ready=0: new frame discarded; held word and flags unchanged; overrun=1 for exactly the next cycle.
- Handshake: out_valid=1 with out_ready=1 and no completion that edge → out_valid=0 next cycle. out_data and flags are held stable while out_valid=1 and out_ready=0. Flags are meaningful only while out_valid=1.
- par_en/par_odd changes after the start tick do not affect the current frame.
- busy=1 in DATA, PARITY, STOP and WAIT_HIGH.

Decomposition:
- Shared uart_pkg (include file): FSM state encodings (IDLE, DATA, PARITY, STOP, WAIT_HIGH), parity-mode constants, DATA_W/STOP_W legal-range checks. The framer/TX side reuses these.
- One natural sub-module: uart_parity_gen (DATA_W-wide XOR reduction with odd/even select), shared with the TX framer.

Test Plan:
- 8N1, DATA_W=8, par_en=0: line bits 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop) → out_valid 1 clk after stop tick; out_data=0x55; all error flags 0.
- Even parity: 0xA3 with parity bit 0 → out_data=0xA3, parity_err=0. Same frame with parity bit 1 → parity_err=1, data still 0xA3.
- STOP_W=2, 0x3C, second stop bit 0 → frame_err=1; FSM in WAIT_HIGH. A following start bit is ignored until a tick with rx_bit=1.
- Break: all ticks rx_bit=0 for a full frame → out_data=0, frame_err=1, break_det=1.
- Overrun: two frames 0x11 then 0x22 with out_ready=0 → out_data stays 0x11, overrun pulses 1 clk. Completion coinciding with out_ready=1 → 0x22 loaded, no overrun.
- Reset mid-frame: assert rst_n=0 after 4 data bits → busy=0, out_valid=0. Next full frame 0x7E (DATA_W=7, odd parity) received correctly.
